// File: rtl/obsidian_pkg.sv
// Shared types and constants for the Obsidian hazard controller: forwarding
// select codes, FSM state encodings, scoreboard slot indices and the XZR index.
package obsidian_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_e;

    // Default index of XZR; the controller exposes it as its ZERO_REG parameter.
    localparam int ZERO_REG_DEFAULT = 31;

    localparam int N_SLOTS  = 3;
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    // Youngest producer wins: an EX-slot match beats a MEM-slot match.
    function automatic fwd_sel_e fwd_pick(input logic used, input logic [N_SLOTS-1:0] match);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (used && match[SLOT_EX]) begin
            sel = FWD_EXMEM;
        end else if (used && match[SLOT_MEM]) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/obsidian_hazard_ctrl_if.sv
// Decode-side bundle between the Obsidian pipeline and its hazard controller.
// The pipeline is the master (drives decode/branch info), the controller the slave.
interface obsidian_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic [REG_W-1:0] id_rd;
    logic             id_use_rn;
    logic             id_use_rm;
    logic             id_wr_rd;
    logic             id_is_load;
    logic             id_is_branch;
    logic             ex_br_resolved;
    logic             ex_br_taken;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       ex_fwd_a_sel;
    logic [1:0]       ex_fwd_b_sel;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm,
               id_wr_rd, id_is_load, id_is_branch, ex_br_resolved, ex_br_taken,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble,
               ex_fwd_a_sel, ex_fwd_b_sel, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm,
               id_wr_rd, id_is_load, id_is_branch, ex_br_resolved, ex_br_taken,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble,
               ex_fwd_a_sel, ex_fwd_b_sel, bubble_cnt
    );

endinterface

// File: rtl/obsidian_hazard_scoreboard.sv
// Three-slot (EX/MEM/WB) shift register of in-flight destinations, with per-slot
// source matches and a per-operand hazard flag (load-use only when FWD_EN=1).
module obsidian_hazard_scoreboard
    import obsidian_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    parameter bit FWD_EN   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_i,
    input  logic               wr_rd_i,
    input  logic               is_load_i,
    input  logic [REG_W-1:0]   rd_i,
    input  logic [REG_W-1:0]   rn_i,
    input  logic [REG_W-1:0]   rm_i,
    output logic [N_SLOTS-1:0] match_a_o,
    output logic [N_SLOTS-1:0] match_b_o,
    output logic               hz_a_o,
    output logic               hz_b_o
);
    localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

    logic             vld_q [N_SLOTS];
    logic [REG_W-1:0] rd_q  [N_SLOTS];
    logic             ld_q  [N_SLOTS];
    logic             vld_d [N_SLOTS];
    logic [REG_W-1:0] rd_d  [N_SLOTS];
    logic             ld_d  [N_SLOTS];

    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            if (gi == SLOT_EX) begin : g_head
                // A bubble or an XZR/no-write instruction occupies EX as an empty slot.
                assign vld_d[gi] = issue_i && wr_rd_i && (rd_i != XZR);
                assign rd_d[gi]  = rd_i;
                assign ld_d[gi]  = is_load_i;
            end else begin : g_tail
                assign vld_d[gi] = vld_q[gi-1];
                assign rd_d[gi]  = rd_q[gi-1];
                assign ld_d[gi]  = ld_q[gi-1];
            end
            assign match_a_o[gi] = vld_q[gi] && (rd_q[gi] == rn_i) && (rn_i != XZR);
            assign match_b_o[gi] = vld_q[gi] && (rd_q[gi] == rm_i) && (rm_i != XZR);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SLOTS; i++) begin
            if (rst) begin
                vld_q[i] <= 1'b0;
                rd_q[i]  <= '0;
                ld_q[i]  <= 1'b0;
            end else begin
                vld_q[i] <= vld_d[i];
                rd_q[i]  <= rd_d[i];
                ld_q[i]  <= ld_d[i];
            end
        end
    end

    // With forwarding only a load still in EX cannot supply its result in time.
    assign hz_a_o = FWD_EN ? (match_a_o[SLOT_EX] && ld_q[SLOT_EX]) : (|match_a_o);
    assign hz_b_o = FWD_EN ? (match_b_o[SLOT_EX] && ld_q[SLOT_EX]) : (|match_b_o);

endmodule

// File: rtl/obsidian_hazard_ctrl.sv
// Obsidian ID-stage hazard controller: RAW stall/bubble, branch hold, EX forwarding
// selects and a saturating bubble counter. Define OBSIDIAN_FWD_EN to enable forwarding.
module obsidian_hazard_ctrl
    import obsidian_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    obsidian_hazard_ctrl_if.slave bus
);
`ifdef OBSIDIAN_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    fwd_sel_e         fwd_a_q, fwd_a_d;
    fwd_sel_e         fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_SLOTS-1:0] match_a, match_b;
    logic               hz_a, hz_b, hazard;
    logic               pc_stall, ifid_stall, ifid_flush, idex_bubble;
    logic               issue, run_path;

    obsidian_hazard_scoreboard #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG),
        .FWD_EN   (FWD_EN)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .issue_i   (issue),
        .wr_rd_i   (bus.id_wr_rd),
        .is_load_i (bus.id_is_load),
        .rd_i      (bus.id_rd),
        .rn_i      (bus.id_rn),
        .rm_i      (bus.id_rm),
        .match_a_o (match_a),
        .match_b_o (match_b),
        .hz_a_o    (hz_a),
        .hz_b_o    (hz_b)
    );

    assign hazard = bus.id_valid && ((bus.id_use_rn && hz_a) || (bus.id_use_rm && hz_b));

    always_comb begin
        state_d     = state_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        issue       = 1'b0;
        run_path    = 1'b0;
        if (rst) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: run_path = 1'b1;
                BR_WAIT: begin
                    if (bus.ex_br_resolved && bus.ex_br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = RUN;
                    end else if (bus.ex_br_resolved) begin
                        run_path = 1'b1;
                        state_d  = RUN;
                    end else begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
            // A not-taken resolve lets the held instruction go through the normal RUN path.
            if (run_path) begin
                if (hazard) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end else begin
                    issue = bus.id_valid;
                    if (bus.id_valid && bus.id_is_branch) begin
                        state_d = BR_WAIT;
                    end
                end
            end
        end
    end

    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (FWD_EN && issue) begin
            fwd_a_d = fwd_pick(bus.id_use_rn, match_a);
            fwd_b_d = fwd_pick(bus.id_use_rm, match_b);
        end
        cnt_d = cnt_q;
        if (idex_bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.ifid_stall   = ifid_stall;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.ex_fwd_a_sel = fwd_a_q;
    assign bus.ex_fwd_b_sel = fwd_b_q;
    assign bus.bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_obsidian_hazard_ctrl.sv
// Directed vector bench for obsidian_hazard_ctrl; expectations follow OBSIDIAN_FWD_EN.
module tb_obsidian_hazard_ctrl;
`ifdef OBSIDIAN_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obsidian_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) ifc ();
    obsidian_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  ifc4 ();

    obsidian_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .CNT_W(16)) dut (
        .clk (clk), .rst (rst), .bus (ifc)
    );
    obsidian_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .CNT_W(4)) dut4 (
        .clk (clk), .rst (rst), .bus (ifc4)
    );

    assign ifc4.id_valid       = ifc.id_valid;
    assign ifc4.id_rn          = ifc.id_rn;
    assign ifc4.id_rm          = ifc.id_rm;
    assign ifc4.id_rd          = ifc.id_rd;
    assign ifc4.id_use_rn      = ifc.id_use_rn;
    assign ifc4.id_use_rm      = ifc.id_use_rm;
    assign ifc4.id_wr_rd       = ifc.id_wr_rd;
    assign ifc4.id_is_load     = ifc.id_is_load;
    assign ifc4.id_is_branch   = ifc.id_is_branch;
    assign ifc4.ex_br_resolved = ifc.ex_br_resolved;
    assign ifc4.ex_br_taken    = ifc.ex_br_taken;

    typedef struct {
        string      name;
        logic       rst, v;
        logic [4:0] rn, rm, rd;
        logic       urn, urm, wr, ld, br, res, tk;
        logic       s, fl, bb;
        logic [1:0] fa, fb;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic add(input string name, input int r, input int v, input int rn, input int rm,
                       input int rd, input int urn, input int urm, input int wr, input int ld,
                       input int br, input int res, input int tk, input int s, input int fl,
                       input int bb, input int fa, input int fb, input int cnt);
        vec_t x;
        x.name = name; x.rst = 1'(r); x.v = 1'(v);
        x.rn = 5'(rn); x.rm = 5'(rm); x.rd = 5'(rd);
        x.urn = 1'(urn); x.urm = 1'(urm); x.wr = 1'(wr); x.ld = 1'(ld);
        x.br = 1'(br); x.res = 1'(res); x.tk = 1'(tk);
        x.s = 1'(s); x.fl = 1'(fl); x.bb = 1'(bb);
        x.fa = 2'(fa); x.fb = 2'(fb); x.cnt = 16'(cnt);
        vecs.push_back(x);
    endtask

    // Shorthands: idle cycle inputs, reset cycle inputs.
    task automatic idle(input string n, input int res, input int tk, input int s, input int fl,
                        input int bb, input int fa, input int fb, input int cnt);
        add(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, res, tk, s, fl, bb, fa, fb, cnt);
    endtask

    task automatic rstrow(input string n, input int fa, input int cnt);
        add(n, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, fa, 0, cnt);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst                = x.rst;
        ifc.id_valid       = x.v;
        ifc.id_rn          = x.rn;
        ifc.id_rm          = x.rm;
        ifc.id_rd          = x.rd;
        ifc.id_use_rn      = x.urn;
        ifc.id_use_rm      = x.urm;
        ifc.id_wr_rd       = x.wr;
        ifc.id_is_load     = x.ld;
        ifc.id_is_branch   = x.br;
        ifc.ex_br_resolved = x.res;
        ifc.ex_br_taken    = x.tk;
    endtask

    task automatic check_row(input vec_t x);
        chk({x.name, ".pc_stall"},    32'(ifc.pc_stall),     32'(x.s));
        chk({x.name, ".ifid_stall"},  32'(ifc.ifid_stall),   32'(x.s));
        chk({x.name, ".ifid_flush"},  32'(ifc.ifid_flush),   32'(x.fl));
        chk({x.name, ".idex_bubble"}, 32'(ifc.idex_bubble),  32'(x.bb));
        chk({x.name, ".fwd_a"},       32'(ifc.ex_fwd_a_sel), 32'(x.fa));
        chk({x.name, ".fwd_b"},       32'(ifc.ex_fwd_b_sel), 32'(x.fb));
        chk({x.name, ".bubble_cnt"},  32'(ifc.bubble_cnt),   32'(x.cnt));
        $display("row %-10s rst=%0d v=%0d stall=%0d flush=%0d bubble=%0d fa=%0d fb=%0d cnt=%0d",
                 x.name, x.rst, x.v, ifc.pc_stall, ifc.ifid_flush, ifc.idex_bubble,
                 ifc.ex_fwd_a_sel, ifc.ex_fwd_b_sel, ifc.bubble_cnt);
    endtask

    task automatic fill();
        // ADD X4,X1,X2 ; SUB X5,X4,X3
        rstrow("rst0", 0, 0);
        add("add_x4", 0, 1, 1, 2, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (FWD) begin
            add("sub_x5", 0, 1, 4, 3, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            idle("sub_ex", 0, 0, 0, 0, 0, 1, 0, 0);
            idle("idle1", 0, 0, 0, 0, 0, 0, 0, 0);
        end else begin
            add("sub_st0", 0, 1, 4, 3, 5, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
            add("sub_st1", 0, 1, 4, 3, 5, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
            add("sub_st2", 0, 1, 4, 3, 5, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2);
            add("sub_iss", 0, 1, 4, 3, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
            idle("sub_ex", 0, 0, 0, 0, 0, 0, 0, 3);
        end
        // LDUR X4,[X1] ; ADD X5,X4,X2
        rstrow("rst1", 0, FWD ? 0 : 3);
        add("ldur_x4", 0, 1, 1, 0, 4, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (FWD) begin
            add("lu_st", 0, 1, 4, 2, 5, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
            add("lu_iss", 0, 1, 4, 2, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            idle("lu_ex", 0, 0, 0, 0, 0, 2, 0, 1);
        end else begin
            add("lu_st0", 0, 1, 4, 2, 5, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
            add("lu_st1", 0, 1, 4, 2, 5, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
            add("lu_st2", 0, 1, 4, 2, 5, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2);
            add("lu_iss", 0, 1, 4, 2, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
            idle("lu_ex", 0, 0, 0, 0, 0, 0, 0, 3);
        end
        // ADD X31,X1,X2 ; ORR X6,X31,X31
        rstrow("rst2", 0, FWD ? 1 : 3);
        add("xzr_add", 0, 1, 1, 2, 31, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("orr_xzr", 0, 1, 31, 31, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("orr_ex", 0, 0, 0, 0, 0, 0, 0, 0);
        // CBZ X0 taken after one wait cycle
        rstrow("rst3", 0, 0);
        add("cbz", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("brw", 0, 1, 1, 2, 7, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add("br_tk", 0, 1, 1, 2, 7, 1, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1);
        idle("after_tk", 0, 0, 0, 0, 0, 0, 0, 2);
        // CBZ X0 not taken: held ADD X7 issues in the resolve cycle
        rstrow("rst4", 0, 2);
        add("cbz2", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("br_nt", 0, 1, 1, 2, 7, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle("res_run", 1, 1, 0, 0, 0, 0, 0, 0);
        // LDUR X0 ; CBZ X0 : branch stalls first, enters BR_WAIT on issue
        rstrow("rst5", 0, 0);
        add("ld_x0", 0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (FWD) begin
            add("cbz_st", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
            add("cbz_iss", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
            idle("brw2", 0, 0, 1, 0, 1, 2, 0, 1);
            idle("tk2", 1, 1, 0, 1, 1, 0, 0, 2);
            idle("after2", 0, 0, 0, 0, 0, 0, 0, 3);
        end else begin
            add("cbz_st0", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
            add("cbz_st1", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1);
            add("cbz_st2", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 2);
            add("cbz_iss", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3);
            idle("brw2", 0, 0, 1, 0, 1, 0, 0, 3);
            idle("tk2", 1, 1, 0, 1, 1, 0, 0, 4);
            idle("after2", 0, 0, 0, 0, 0, 0, 0, 5);
        end
        // Reset in the middle of BR_WAIT; a later resolve must be ignored
        rstrow("rst6", 0, FWD ? 3 : 5);
        add("cbz3", 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("brw3", 0, 0, 1, 0, 1, 0, 0, 0);
        rstrow("rst_mid", 0, 1);
        idle("post_rst", 1, 1, 0, 0, 0, 0, 0, 0);
        add("post_add", 0, 1, 1, 2, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_t z;
        z = '{name: "init", rst: 1'b1, default: '0};
        drive(z);
        fill();
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check_row(vecs[i]);
        end

        // Saturation: hold BR_WAIT for 20 cycles; the CNT_W=4 instance stops at 15.
        @(negedge clk);
        drive(z);
        @(negedge clk);
        z.rst = 1'b0; z.v = 1'b1; z.urn = 1'b1; z.br = 1'b1;
        drive(z);
        z = '{name: "wait", rst: 1'b0, default: '0};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(z);
            #2;
            chk("sat.cnt4", 32'(ifc4.bubble_cnt), (i > 15) ? 32'd15 : 32'(i));
            chk("sat.cnt16", 32'(ifc.bubble_cnt), 32'(i));
            $display("sat cycle %0d cnt4=%0d cnt16=%0d", i, ifc4.bubble_cnt, ifc.bubble_cnt);
        end
        @(negedge clk);
        z.res = 1'b1; z.tk = 1'b1;
        drive(z);
        #2;
        chk("sat.hold4", 32'(ifc4.bubble_cnt), 32'd15);
        chk("sat.cnt20", 32'(ifc.bubble_cnt), 32'd20);
        chk("sat.flush", 32'(ifc.ifid_flush), 32'd1);
        @(negedge clk);
        z.res = 1'b0; z.tk = 1'b0;
        drive(z);
        #2;
        chk("sat.hold4b", 32'(ifc4.bubble_cnt), 32'd15);
        chk("sat.cnt21", 32'(ifc.bubble_cnt), 32'd21);
        chk("sat.noflush", 32'(ifc.ifid_flush), 32'd0);
        $display("sat end cnt4=%0d cnt16=%0d", ifc4.bubble_cnt, ifc.bubble_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
